reg_ctx_engine: RTL and testbench

Context save/restore engine for the Simple CPU register file. It drives the register file's read and write ports to stream registers FIRST_REG..LAST_REG out on a valid/ready port (save), or to write an incoming valid/ready stream back into them (restore). It sits beside the datapath. While `busy` is high, an external mux hands the register file ports to this block.

---
 rtl/simple_cpu_pkg.sv | 30 +++
 rtl/reg_ctx_engine.sv | 147 ++++++++++++++
 tb/tb_reg_ctx_engine.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/simple_cpu_pkg.sv
// simple_cpu_pkg
// Shared definitions for the Simple CPU blocks: register file geometry and
// the state encoding of the context save/restore engine.
package simple_cpu_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;
  localparam int NUM_REGS   = 32;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_SAVE       = 2'd1,
    ST_SAVE_DRAIN = 2'd2,
    ST_RESTORE    = 2'd3
  } ctx_state_t;

  // Advance a register pointer, holding it once it reaches the last register
  // so that a context ending at register 31 never wraps to register 0.
  function automatic logic [REG_ADDR_W-1:0] ptr_next(
    input logic [REG_ADDR_W-1:0] ptr,
    input logic [REG_ADDR_W-1:0] last
  );
    if (ptr == last) begin
      return ptr;
    end else begin
      return ptr + 5'd1;
    end
  endfunction

endpackage

// File: rtl/reg_ctx_engine.sv
// reg_ctx_engine
// Context save/restore engine for the Simple CPU register file.
// Save:    streams R[FIRST_REG..LAST_REG] out on out_valid/out_ready with the
//          register index alongside (out_addr); data is captured through
//          read port 1 at the edge where each beat is loaded.
// Restore: accepts in_valid/in_ready beats and writes them, in order, into
//          R[FIRST_REG..LAST_REG] through the register file write port.
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   save_start, restore_start   start pulses, sampled only while idle
//   abort                       cancel the running operation (no done)
//   busy, done                  operation in progress / completion pulse
//   rf_read_addr_1/2, rf_read_data_1/2   register file read ports
//   rf_reg_write, rf_write_addr, rf_write_data   register file write port
//   out_valid/out_ready/out_data/out_addr         save stream
//   in_valid/in_ready/in_data                     restore stream
module reg_ctx_engine
  import simple_cpu_pkg::*;
#(
  parameter int FIRST_REG = 1,
  parameter int LAST_REG  = 31
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  save_start,
  input  logic                  restore_start,
  input  logic                  abort,
  output logic                  busy,
  output logic                  done,
  output logic [REG_ADDR_W-1:0] rf_read_addr_1,
  output logic [REG_ADDR_W-1:0] rf_read_addr_2,
  input  logic [REG_DATA_W-1:0] rf_read_data_1,
  input  logic [REG_DATA_W-1:0] rf_read_data_2,
  output logic                  rf_reg_write,
  output logic [REG_ADDR_W-1:0] rf_write_addr,
  output logic [REG_DATA_W-1:0] rf_write_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [REG_DATA_W-1:0] out_data,
  output logic [REG_ADDR_W-1:0] out_addr,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [REG_DATA_W-1:0] in_data
);

  localparam logic [REG_ADDR_W-1:0] FIRST_A = REG_ADDR_W'(FIRST_REG);
  localparam logic [REG_ADDR_W-1:0] LAST_A  = REG_ADDR_W'(LAST_REG);

  ctx_state_t            state_r;
  logic [REG_ADDR_W-1:0] ptr_r;
  logic                  done_r;
  logic                  out_valid_r;
  logic [REG_DATA_W-1:0] out_data_r;
  logic [REG_ADDR_W-1:0] out_addr_r;
  logic                  unused_rd2_s;

  // Read port 2 is not needed by this block.
  assign unused_rd2_s = ^rf_read_data_2;

  // Control FSM, register pointer and the registered save-stream beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      ptr_r       <= FIRST_A;
      done_r      <= 1'b0;
      out_valid_r <= 1'b0;
      out_data_r  <= 32'd0;
      out_addr_r  <= 5'd0;
    end else if (abort) begin
      // Abort wins over any handshake in the same cycle; beat contents are
      // left as they were since out_valid drops.
      state_r     <= ST_IDLE;
      ptr_r       <= FIRST_A;
      done_r      <= 1'b0;
      out_valid_r <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          // Save has priority when both starts arrive together.
          if (save_start) begin
            out_data_r  <= rf_read_data_1;
            out_addr_r  <= ptr_r;
            out_valid_r <= 1'b1;
            ptr_r       <= ptr_next(FIRST_A, LAST_A);
            state_r     <= (FIRST_A == LAST_A) ? ST_SAVE_DRAIN : ST_SAVE;
          end else if (restore_start) begin
            ptr_r   <= FIRST_A;
            state_r <= ST_RESTORE;
          end else begin
            ptr_r <= FIRST_A;
          end
        end
        ST_SAVE: begin
          // ptr already addresses the next register, so its value is on
          // rf_read_data_1 ready to be loaded when the current beat leaves.
          if (out_valid_r && out_ready) begin
            out_data_r <= rf_read_data_1;
            out_addr_r <= ptr_r;
            ptr_r      <= ptr_next(ptr_r, LAST_A);
            if (ptr_r == LAST_A) begin
              state_r <= ST_SAVE_DRAIN;
            end
          end
        end
        ST_SAVE_DRAIN: begin
          if (out_valid_r && out_ready) begin
            out_valid_r <= 1'b0;
            done_r      <= 1'b1;
            ptr_r       <= FIRST_A;
            state_r     <= ST_IDLE;
          end
        end
        ST_RESTORE: begin
          if (in_valid) begin
            if (ptr_r == LAST_A) begin
              done_r  <= 1'b1;
              ptr_r   <= FIRST_A;
              state_r <= ST_IDLE;
            end else begin
              ptr_r <= ptr_r + 5'd1;
            end
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          ptr_r       <= FIRST_A;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign busy           = (state_r != ST_IDLE);
  assign done           = done_r;
  assign out_valid      = out_valid_r;
  assign out_data       = out_data_r;
  assign out_addr       = out_addr_r;
  assign rf_read_addr_1 = ptr_r;
  assign rf_read_addr_2 = 5'd0;
  assign rf_write_addr  = ptr_r;
  assign rf_write_data  = in_data;
  assign in_ready       = (state_r == ST_RESTORE);
  // The write is suppressed in an abort cycle so a cancelled beat never lands.
  assign rf_reg_write   = (state_r == ST_RESTORE) && in_valid && !abort;

endmodule

// File: tb/tb_reg_ctx_engine.sv
// tb_reg_ctx_engine
// Self-checking bench for reg_ctx_engine: a behavioural register file, a
// table of single-cycle start/abort vectors, hand-written save/restore/abort
// sequences and randomized operations checked against a sequence model.
module tb_reg_ctx_engine;

  localparam int FIRST = 1;
  localparam int LAST  = 31;
  localparam int N     = LAST - FIRST + 1;

  logic        clk = 1'b0;
  logic        rst, save_start, restore_start, abort;
  logic        busy, done;
  logic [4:0]  rf_read_addr_1, rf_read_addr_2, rf_write_addr, out_addr;
  logic [31:0] rf_read_data_1, rf_read_data_2, rf_write_data, out_data, in_data;
  logic        rf_reg_write, out_valid, out_ready, in_valid, in_ready;

  always #5 clk = ~clk;

  reg_ctx_engine #(.FIRST_REG(FIRST), .LAST_REG(LAST)) dut (
    .clk(clk), .rst(rst), .save_start(save_start), .restore_start(restore_start),
    .abort(abort), .busy(busy), .done(done),
    .rf_read_addr_1(rf_read_addr_1), .rf_read_addr_2(rf_read_addr_2),
    .rf_read_data_1(rf_read_data_1), .rf_read_data_2(rf_read_data_2),
    .rf_reg_write(rf_reg_write), .rf_write_addr(rf_write_addr),
    .rf_write_data(rf_write_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_addr(out_addr), .in_valid(in_valid),
    .in_ready(in_ready), .in_data(in_data)
  );

  // Register file environment: preload port plus the DUT write port.
  logic [31:0] rf_mem [32];
  logic        pre_we;
  logic [4:0]  pre_addr;
  logic [31:0] pre_data;

  always @(posedge clk) begin
    if (pre_we) rf_mem[pre_addr] <= pre_data;
    else if (rf_reg_write && rf_write_addr != 5'd0) rf_mem[rf_write_addr] <= rf_write_data;
  end
  assign rf_read_data_1 = (rf_read_addr_1 == 5'd0) ? 32'd0 : rf_mem[rf_read_addr_1];
  assign rf_read_data_2 = 32'hDEAD_BEEF;

  // Expected register contents.
  logic [31:0] mdl_regs [32];

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"}, busy, 32'd0);
    chk({tag, "_done"}, done, 32'd0);
    chk({tag, "_out_valid"}, out_valid, 32'd0);
    chk({tag, "_out_data"}, out_data, 32'd0);
    chk({tag, "_out_addr"}, out_addr, 32'd0);
    chk({tag, "_in_ready"}, in_ready, 32'd0);
    chk({tag, "_rf_reg_write"}, rf_reg_write, 32'd0);
    chk({tag, "_rd_addr_1"}, rf_read_addr_1, 32'(FIRST));
    chk({tag, "_rd_addr_2"}, rf_read_addr_2, 32'd0);
  endtask

  task automatic preload();
    for (int i = 0; i < 32; i++) begin
      @(posedge clk); #2;
      pre_we   = 1'b1;
      pre_addr = 5'(i);
      pre_data = (i == 0) ? 32'd0 : 32'(i) * 32'h0101_0101;
      mdl_regs[i] = pre_data;
    end
    @(posedge clk); #2;
    pre_we = 1'b0;
  endtask

  // Runs one operation cycle by cycle. The model knows only: the operation is
  // active from the cycle after the start edge until its N-th handshake or an
  // abort, beat i carries R[FIRST+i], and done follows the last handshake.
  task automatic run_op(input bit is_save, input bit both, input int mode,
                        input int abort_after, input bit inject);
    logic [31:0] snap [32];
    int beats = 0;
    int trail = 0;
    int c = 0;
    bit active = 1'b1;
    bit exp_done = 1'b0;
    bit aborted = 1'b0;
    bit drv = 1'b0;
    bit ab = 1'b0;
    logic [4:0] idx;
    snap = mdl_regs;
    @(posedge clk); #2;
    save_start    = is_save | both;
    restore_start = !is_save | both;
    out_ready = 1'b0; in_valid = 1'b0; abort = 1'b0;
    forever begin
      @(posedge clk); #2;
      c++;
      save_start    = 1'b0;
      restore_start = inject && (c == 5);
      case (mode)
        0:       drv = 1'b1;
        1:       drv = (c % 3 == 1);
        default: drv = ($urandom_range(0, 3) != 0);
      endcase
      ab    = active && (abort_after >= 0) && (beats == abort_after);
      abort = ab;
      idx   = 5'(FIRST + beats);
      if (is_save) begin
        out_ready = drv;
        in_valid  = 1'($urandom_range(0, 1));
      end else begin
        in_valid  = drv;
        in_data   = (mode == 3) ? $urandom() : 32'h7777_0000 + 32'(idx);
        out_ready = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      chk("busy", busy, 32'(active));
      chk("done", done, 32'(exp_done));
      exp_done = 1'b0;
      if (is_save) begin
        chk("save_out_valid", out_valid, 32'(active));
        chk("save_in_ready", in_ready, 32'd0);
        chk("save_rf_write", rf_reg_write, 32'd0);
        if (active) begin
          chk("save_out_addr", out_addr, 32'(idx));
          chk("save_out_data", out_data, snap[idx]);
        end
      end else begin
        chk("rst_in_ready", in_ready, 32'(active));
        chk("rst_out_valid", out_valid, 32'd0);
        chk("rst_rf_write", rf_reg_write, 32'(active && drv && !ab));
      end
      if (active) begin
        if (ab) begin
          active  = 1'b0;
          aborted = 1'b1;
        end else if (drv) begin
          if (!is_save) mdl_regs[idx] = in_data;
          beats++;
          if (beats == N) begin
            active   = 1'b0;
            exp_done = 1'b1;
          end
        end
      end else begin
        trail++;
      end
      if (trail == 4) break;
      if (c >= 600) begin
        chk("op_timeout", 32'(c), 32'd0);
        break;
      end
    end
    abort = 1'b0; in_valid = 1'b0; out_ready = 1'b0; restore_start = 1'b0;
    chk("beat_count", 32'(beats), aborted ? 32'(abort_after) : 32'(N));
    for (int i = 0; i < 32; i++) chk($sformatf("reg_%0d", i), rf_mem[i], mdl_regs[i]);
  endtask

  typedef struct {
    logic       ss;
    logic       rs;
    logic       ab;
    logic       e_busy;
    logic       e_ov;
    logic       e_ir;
  } vec_t;

  vec_t vecs [6];

  initial begin
    vecs[0] = '{ss: 1'b0, rs: 1'b0, ab: 1'b0, e_busy: 1'b0, e_ov: 1'b0, e_ir: 1'b0};
    vecs[1] = '{ss: 1'b1, rs: 1'b0, ab: 1'b0, e_busy: 1'b1, e_ov: 1'b1, e_ir: 1'b0};
    vecs[2] = '{ss: 1'b0, rs: 1'b1, ab: 1'b0, e_busy: 1'b1, e_ov: 1'b0, e_ir: 1'b1};
    vecs[3] = '{ss: 1'b1, rs: 1'b1, ab: 1'b0, e_busy: 1'b1, e_ov: 1'b1, e_ir: 1'b0};
    vecs[4] = '{ss: 1'b1, rs: 1'b0, ab: 1'b1, e_busy: 1'b0, e_ov: 1'b0, e_ir: 1'b0};
    vecs[5] = '{ss: 1'b0, rs: 1'b1, ab: 1'b1, e_busy: 1'b0, e_ov: 1'b0, e_ir: 1'b0};

    rst = 1'b1; save_start = 1'b0; restore_start = 1'b0; abort = 1'b0;
    out_ready = 1'b0; in_valid = 1'b0; in_data = 32'd0;
    pre_we = 1'b0; pre_addr = 5'd0; pre_data = 32'd0;

    // Reset held for two cycles.
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      @(negedge clk);
      check_reset_outputs("reset");
    end
    @(posedge clk); #2;
    rst = 1'b0;

    preload();

    // Start/abort vectors from idle, each followed by an abort back to idle.
    for (int v = 0; v < 6; v++) begin
      @(posedge clk); #2;
      save_start = vecs[v].ss; restore_start = vecs[v].rs; abort = vecs[v].ab;
      @(posedge clk); #2;
      save_start = 1'b0; restore_start = 1'b0; abort = 1'b0;
      @(negedge clk);
      chk($sformatf("vec%0d_busy", v), busy, 32'(vecs[v].e_busy));
      chk($sformatf("vec%0d_out_valid", v), out_valid, 32'(vecs[v].e_ov));
      chk($sformatf("vec%0d_in_ready", v), in_ready, 32'(vecs[v].e_ir));
      chk($sformatf("vec%0d_done", v), done, 32'd0);
      if (vecs[v].e_ov) chk($sformatf("vec%0d_out_addr", v), out_addr, 32'(FIRST));
      @(posedge clk); #2;
      abort = 1'b1;
      @(posedge clk); #2;
      abort = 1'b0;
      @(negedge clk);
      chk($sformatf("vec%0d_idle_busy", v), busy, 32'd0);
      chk($sformatf("vec%0d_idle_done", v), done, 32'd0);
    end

    run_op(1'b1, 1'b0, 0, -1, 1'b0);   // full save, out_ready held high
    run_op(1'b1, 1'b0, 1, -1, 1'b0);   // backpressure 1,0,0,...
    run_op(1'b0, 1'b0, 2, -1, 1'b0);   // restore with in_valid gaps
    run_op(1'b1, 1'b1, 0, -1, 1'b1);   // both starts + restore_start mid-save
    run_op(1'b0, 1'b0, 3, 5, 1'b0);    // abort after the 5th restore handshake
    run_op(1'b1, 1'b0, 0, -1, 1'b0);   // save after abort

    // Reset in the middle of a save.
    @(posedge clk); #2;
    save_start = 1'b1; out_ready = 1'b1;
    @(posedge clk); #2;
    save_start = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    @(posedge clk); #2;
    rst = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    check_reset_outputs("midrst");

    for (int r = 0; r < 8; r++) begin
      run_op(1'($urandom_range(0, 1)), 1'b0, 2 + int'($urandom_range(0, 1)),
             ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(0, N - 1)), 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
